// File: rtl/audio_sample_fifo_core.sv
// Stereo sample FIFO between an MMIO slot and an I2S transmitter.
// Software pushes 32-bit L/R words, the transmitter pops them with valid/ready.
module audio_sample_fifo_core #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        irq
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [4:0] A_DATA   = 5'd0;
  localparam logic [4:0] A_STATUS = 5'd1;
  localparam logic [4:0] A_CTRL   = 5'd2;
  localparam logic [4:0] A_CLEAR  = 5'd3;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  logic          irq_en_q, irq_en_d;
  logic [AW-1:0] thr_q, thr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          irq_q, irq_d;

  logic sel_data, sel_status, sel_ctrl, sel_clear;
  logic wr_acc;
  logic push_req, push_ok, pop;
  logic ctrl_we, clr_we;
  logic flush, clr_ovf, clr_unf;
  logic ovf_set, unf_set;
  logic empty, full, low;

  logic [31:0] status_w;
  logic [31:0] ctrl_w;

  assign sel_data   = (addr == A_DATA);
  assign sel_status = (addr == A_STATUS);
  assign sel_ctrl   = (addr == A_CTRL);
  assign sel_clear  = (addr == A_CLEAR);

  assign wr_acc   = cs & write;
  assign push_req = wr_acc & sel_data;
  assign ctrl_we  = wr_acc & sel_ctrl;
  assign clr_we   = wr_acc & sel_clear;

  assign flush   = clr_we & wr_data[2];
  assign clr_ovf = clr_we & wr_data[0];
  assign clr_unf = clr_we & wr_data[1];

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_C);
  assign low   = (count_q < {1'b0, thr_q});

  assign sample_valid = en_q & ~empty;
  assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;
  assign irq          = irq_q;

  assign pop     = sample_valid & sample_ready;
  // A pop frees the slot this same edge, so a full FIFO still accepts.
  assign push_ok = push_req & (~full | pop);

  assign ovf_set = push_req & full & ~pop & ~flush;
  assign unf_set = en_q & sample_ready & empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    if (ctrl_we) begin
      en_d     = wr_data[0];
      irq_en_d = wr_data[1];
      thr_d    = wr_data[8 +: AW];
    end
    ovf_d = (ovf_q & ~clr_ovf) | ovf_set;
    unf_d = (unf_q & ~clr_unf) | unf_set;
    irq_d = irq_en_d & en_d & (count_d < {1'b0, thr_d});
  end

  always_comb begin
    status_w       = '0;
    status_w[0]    = empty;
    status_w[1]    = full;
    status_w[2]    = low;
    status_w[3]    = ovf_q;
    status_w[4]    = unf_q;
    status_w[15:8] = 8'(count_q);
  end

  always_comb begin
    ctrl_w            = '0;
    ctrl_w[0]         = en_q;
    ctrl_w[1]         = irq_en_q;
    ctrl_w[8 +: AW]   = thr_q;
  end

  always_comb begin
    rd_data = '0;
    if (cs & read) begin
      unique case (1'b1)
        sel_status: rd_data = status_w;
        sel_ctrl:   rd_data = ctrl_w;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok & ~flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_audio_sample_fifo_core.sv
// Bench for audio_sample_fifo_core: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_audio_sample_fifo_core;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        irq;

  audio_sample_fifo_core #(.DEPTH_LOG2(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs           (cs),
    .write        (write),
    .read         (read),
    .addr         (addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  bit m_en, m_ien, m_ovf, m_unf, m_irq;
  int m_thr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_en = 0; m_ien = 0; m_ovf = 0; m_unf = 0; m_irq = 0;
    m_thr = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n = mq.size();
    s = '0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = (n < m_thr);
    s[3] = m_ovf;
    s[4] = m_unf;
    s[15:8] = 8'(n);
    return s;
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (a == 5'd1) return m_status();
    if (a == 5'd2) return {18'd0, 6'(m_thr), 6'd0, m_ien, m_en};
    return 32'd0;
  endfunction

  task automatic step(bit c, bit w, bit r, logic [4:0] a,
                      logic [31:0] d, bit rdy);
    bit vld, pop, push, flush, clr_we, was_empty;
    bit ovf_s, unf_s;
    cs = c; write = w; read = r; addr = a;
    wr_data = d; sample_ready = rdy;
    #1;
    vld = m_en && (mq.size() > 0);
    chk("valid", 32'(sample_valid), 32'(vld));
    chk("data", sample_data, vld ? mq[0] : 32'd0);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rd", rd_data, (c && r) ? m_rd(a) : 32'd0);
    was_empty = (mq.size() == 0);
    pop    = vld && rdy;
    push   = c && w && (a == 5'd0);
    clr_we = c && w && (a == 5'd3);
    flush  = clr_we && d[2];
    ovf_s = 0;
    unf_s = m_en && rdy && was_empty && !flush;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else ovf_s = 1;
      end
    end
    m_ovf = (m_ovf && !(clr_we && d[0])) || ovf_s;
    m_unf = (m_unf && !(clr_we && d[1])) || unf_s;
    if (c && w && (a == 5'd2)) begin
      m_en = d[0]; m_ien = d[1]; m_thr = int'(d[13:8]);
    end
    m_irq = m_ien && m_en && (mq.size() < m_thr);
    @(negedge clk);
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d, bit rdy);
    step(1, 1, 0, a, d, rdy);
  endtask

  task automatic rd(logic [4:0] a);
    step(1, 0, 1, a, 32'd0, 0);
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 5'd0, 32'd0, rdy);
  endtask

  initial begin
    int pct;
    m_reset();
    #1;
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_data", sample_data, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(5'd1);
    chk("rst_status", rd_data, 32'h1);

    // first push becomes visible one cycle later
    wr(5'd2, 32'h1, 0);
    wr(5'd0, 32'h1234ABCD, 0);
    chk("r22_valid", 32'(sample_valid), 32'd1);
    chk("r22_data", sample_data, 32'h1234ABCD);
    rd(5'd1);
    chk("r22_cnt", 32'(rd_data[15:8]), 32'd1);
    wr(5'd3, 32'h4, 0);

    // fill while stalled, then overflow
    wr(5'd2, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) wr(5'd0, $urandom, 0);
    wr(5'd0, 32'hDEADBEEF, 0);
    rd(5'd1);
    chk("r23_full", 32'(rd_data[1]), 32'd1);
    chk("r23_ovf", 32'(rd_data[3]), 32'd1);
    chk("r23_cnt", 32'(rd_data[15:8]), 32'd64);

    // full with simultaneous push and pop
    wr(5'd3, 32'h1, 0);
    wr(5'd2, 32'h1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 5'd0, $urandom, 1);
    rd(5'd1);
    chk("r24_cnt", 32'(rd_data[15:8]), 32'd64);
    chk("r24_ovf", 32'(rd_data[3]), 32'd0);
    for (int i = 0; i < DEPTH; i++) idle(1);

    // underflow then clear
    idle(1);
    rd(5'd1);
    chk("r25_unf", 32'(rd_data[4]), 32'd1);
    wr(5'd3, 32'h2, 0);
    rd(5'd1);
    chk("r25_clr", 32'(rd_data[4]), 32'd0);

    // low-watermark irq
    wr(5'd2, 32'h803, 0);
    for (int i = 0; i < 7; i++) wr(5'd0, $urandom, 0);
    chk("r26_irq7", 32'(irq), 32'd1);
    wr(5'd0, $urandom, 0);
    chk("r26_irq8", 32'(irq), 32'd0);
    wr(5'd3, 32'h4, 0);
    chk("r26_irqf", 32'(irq), 32'd1);
    rd(5'd1);
    chk("r26_cnt", 32'(rd_data[15:8]), 32'd0);

    // reset mid-stream
    wr(5'd2, 32'h1403, 0);
    for (int i = 0; i < 10; i++) wr(5'd0, $urandom, 0);
    cs = 0; write = 0; read = 0;
    reset_n = 1'b0;
    #1;
    chk("r27_valid", 32'(sample_valid), 32'd0);
    chk("r27_data", sample_data, 32'd0);
    chk("r27_irq", 32'(irq), 32'd0);
    chk("r27_rd", rd_data, 32'd0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(5'd1);
    chk("r27_status", rd_data, 32'h1);
    rd(5'd2);
    chk("r27_ctrl", rd_data, 32'h0);
    wr(5'd2, 32'h1, 0);
    wr(5'd0, 32'hCAFE0001, 0);
    chk("r27_head", sample_data, 32'hCAFE0001);

    // randomized traffic
    for (int ph = 0; ph < 8; ph++) begin
      pct = (ph % 4 == 0) ? 5 : (ph % 4 == 1) ? 50 : (ph % 4 == 2) ? 95 : 30;
      for (int i = 0; i < 500; i++) begin
        int r;
        bit rdy;
        logic [31:0] d;
        r = int'($urandom_range(0, 99));
        rdy = ($urandom_range(0, 99) < pct);
        d = $urandom;
        if (r < 45) wr(5'd0, d, rdy);
        else if (r < 55) step(1, 0, 1, 5'($urandom_range(0, 31)), 0, rdy);
        else if (r < 58) wr(5'($urandom_range(4, 31)), d, rdy);
        else if (r < 61) begin
          d[0] = ($urandom_range(0, 4) != 0);
          wr(5'd2, d, rdy);
        end else if (r < 64) begin
          d = 32'($urandom_range(0, 3));
          if ($urandom_range(0, 5) == 0) d[2] = 1'b1;
          wr(5'd3, d, rdy);
        end else idle(rdy);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo_core.md
AUDIO_SAMPLE_FIFO_CORE -- requirements
Module: audio_sample_fifo_core

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, FIFO depth = 2**DEPTH_LOG2 stereo samples.
REQ-002 SHALL have ports:
- clk  input  1  system clock; all logic single-domain, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  slot select from MMIO bus.
- write  input  1  write strobe, qualified by cs.
- read  input  1  read strobe, qualified by cs.
- addr  input  5  word address within slot.
- wr_data  input  32  write data.
- rd_data  output  32  read data.
- sample_data  output  32  FIFO head; [31:16] left, [15:0] right, two's complement.
- sample_valid  output  1  head sample available.
- sample_ready  input  1  downstream (I2S transmitter) accepts head this cycle.
- irq  output  1  level interrupt, low-watermark.

Function
REQ-003 Register map by addr: 0 DATA (W), 1 STATUS (R), 2 CTRL (R/W), 3 CLEAR (W); all other addresses read 0, writes ignored.
REQ-004 Write to DATA (cs&write, addr=0) SHALL push wr_data when count < DEPTH; when full and no pop that cycle, data discarded and ovf sticky set.
REQ-005 STATUS SHALL read: [0] empty, [1] full, [2] low (count < thr), [3] ovf, [4] unf, [15:8] count zero-extended (width DEPTH_LOG2+1, range 0..DEPTH), other bits 0.
REQ-006 CTRL SHALL hold [0] en, [1] irq_en, [13:8] thr (DEPTH_LOG2 bits); read back same fields, other bits 0.
REQ-007 Write to CLEAR SHALL: [0]=1 clear ovf, [1]=1 clear unf, [2]=1 flush (pointers and count to 0); bits independent, effect next edge.
REQ-008 rd_data SHALL be combinational: selected register when cs&read, else 0; reads have no side effects.
REQ-009 sample_valid SHALL equal en & !empty; sample_data SHALL equal FIFO head when sample_valid, else 0.
REQ-010 Pop SHALL occur on clock edge where sample_valid & sample_ready; head advances, count decrements.
REQ-011 en & sample_ready & empty SHALL set unf sticky on that edge.
REQ-012 Simultaneous push and pop SHALL both execute, count unchanged, including when full (push accepted, no ovf).
REQ-013 Push to empty FIFO SHALL make sample_valid high the next cycle (latency 1), head = pushed data.
REQ-014 Flush SHALL win over same-cycle push and pop: count 0 afterwards, pushed data discarded, no ovf/unf set by that cycle.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-016 irq SHALL be registered: irq = irq_en & en & (count < thr), updated each edge from post-update count.
REQ-017 en=0 SHALL stall output (sample_valid 0) while still accepting pushes; contents preserved.
REQ-018 Sticky set and CLEAR clear on same edge: set SHALL win.

Reset
REQ-019 reset_n low SHALL asynchronously force pointers, count, en, irq_en, thr, ovf, unf, irq to 0; sample_valid 0, sample_data 0.
REQ-020 Reset asserted mid-operation SHALL discard FIFO contents; first push after release lands at head.
REQ-021 FIFO storage memory need not be reset.

Verification
REQ-022 Reset, write CTRL=0x1, push 0x1234ABCD, sample_ready=0 -> next cycle sample_valid=1, sample_data=0x1234ABCD, STATUS count=1.
REQ-023 en=0, push 64 words, push 65th -> STATUS full=1, ovf=1, count=64; 65th word never output.
REQ-024 Full FIFO, en=1, sample_ready=1 with push same cycle -> count stays 64, no ovf, data order preserved over 64 pops.
REQ-025 en=1, sample_ready=1, FIFO empty -> unf=1; CLEAR=0x2 -> unf=0 next cycle.
REQ-026 CTRL en=1, irq_en=1, thr=8, count=7 -> irq=1; push one -> irq=0 next cycle; CLEAR=0x4 -> count=0, irq=1.
REQ-027 Push 10 words, assert reset_n low mid-stream -> all outputs 0 immediately; after release STATUS=0x1 (empty), CTRL reads 0.
